apb_timer_cfg_master: RTL and testbench
=======================================

APB_TIMER_CFG_MASTER -- requirements
Module: apb_timer_cfg_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles before abort (used only when timeout is compiled in).
REQ-003 SHALL have port HCLK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port HRESETn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid_i  in  1  command valid.
REQ-006 SHALL have port req_ready_o  out  1  command accepted when high with req_valid_i.
REQ-007 SHALL have port req_write_i  in  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i  in  ADDR_WIDTH  byte address.
REQ-009 SHALL have port req_wdata_i  in  32  write data.
REQ-010 SHALL have port rsp_valid_o  out  1  response valid.
REQ-011 SHALL have port rsp_ready_i  in  1  response consumed.
REQ-012 SHALL have port rsp_rdata_o  out  32  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err_o  out  1  PSLVERR, misalignment or timeout.
REQ-014 SHALL have port rsp_timeout_o  out  1  timeout abort flag.
REQ-015 SHALL have APB initiator ports PSEL, PENABLE, PWRITE out 1; PADDR out ADDR_WIDTH; PWDATA out 32; PREADY in 1; PRDATA in 32; PSLVERR in 1.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-017 IDLE: req_ready_o=1; all APB outputs 0; on req_valid_i, capture write/addr/wdata -> SETUP.
REQ-018 req_ready_o SHALL be 0 in SETUP, ACCESS and RESP; one outstanding command maximum.
REQ-019 Misaligned request (req_addr_i[1:0] != 0) SHALL skip APB and go IDLE -> RESP with rsp_err_o=1, rsp_rdata_o=0.
REQ-020 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from captured values; exactly one cycle; -> ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL be identical to SETUP; hold until PREADY=1.
REQ-022 On PREADY=1 in ACCESS: register PRDATA (reads only), PSLVERR -> rsp_err_o; PSEL/PENABLE SHALL be 0 the next cycle; -> RESP.
REQ-023 PWDATA SHALL be 0 during read transfers.
REQ-024 RESP: rsp_valid_o=1, rsp_* stable until rsp_ready_i=1; then -> IDLE; rsp_* cleared.
REQ-025 Latency: accept at edge N, PSEL at N+1, PENABLE at N+2, zero-wait rsp_valid_o at N+3; next accept earliest the cycle after rsp handshake.
REQ-026 PRDATA and PSLVERR SHALL be ignored except in ACCESS with PREADY=1.
REQ-027 rsp_rdata_o SHALL be 0 when PSLVERR=1.

Reset
REQ-028 HRESETn=0 at a rising edge SHALL force IDLE and zero every output except req_ready_o, which SHALL be 1 after reset release (0 while held in reset).
REQ-029 Reset during SETUP/ACCESS/RESP SHALL abort: PSEL/PENABLE 0 from the next edge, pending response discarded, no rsp_valid_o.

Configuration
REQ-030 Macro APB_TIMER_CFG_MASTER_TIMEOUT_EN defined: 
ACCESS-cycle counter (cleared on SETUP entry); at TIMEOUT_CYCLES cycles without PREADY, deassert PSEL/PENABLE, -> RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-031 Macro undefined: no counter logic; ACCESS waits indefinitely; rsp_timeout_o tied 0.

Verification
REQ-032 Write addr 0x004 data 0x0000_00FF, PREADY=1 -> PSEL N+1, PENABLE N+2, PWDATA=0xFF, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
REQ-033 Read addr 0x008, PREADY low 3 cycles, PRDATA=0x1234_5678 -> ACCESS 4 cycles, signals stable, rsp_rdata=0x1234_5678.
REQ-034 Read addr 0x00C with PSLVERR=1 -> rsp_err=1, rsp_rdata=0; addr 0x002 -> no PSEL, rsp_err=1 one cycle after accept.
REQ-035 rsp_ready_i held 0 for 5 cycles with req_valid_i=1 -> req_ready_o=0, no new PSEL until handshake.
REQ-036 HRESETn=0 in ACCESS -> PSEL=0 next edge, no rsp_valid_o; following write completes normally.
REQ-037 Macro defined, TIMEOUT_CYCLES=16, PREADY stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; macro undefined -> PSEL held >100 cycles.

Source files
------------

// File: rtl/apb_timer_cfg_master.sv
// APB initiator: one req/rsp command at a time becomes an APB SETUP/ACCESS transfer; misaligned commands answer with an error without touching APB.
// Define APB_TIMER_CFG_MASTER_TIMEOUT_EN to abort an ACCESS phase that exceeds TIMEOUT_CYCLES cycles.
module apb_timer_cfg_master #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    input  logic                  PREADY,
    input  logic [31:0]           PRDATA,
    input  logic                  PSLVERR
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  misaligned;
    logic                  timeout_hit;
    logic                  apb_busy;

    assign misaligned = (req_addr_i[1:0] != 2'b00);

`ifdef APB_TIMER_CFG_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    // Counts ACCESS cycles without PREADY; expires on the last allowed cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_SETUP)
            cnt_d = '0;
        else if (state_q == S_ACCESS && !PREADY)
            cnt_d = cnt_q + 1'b1;
    end

    assign timeout_hit = (state_q == S_ACCESS) && !PREADY &&
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_IDLE && req_valid_i)
            tmo_d = 1'b0;
        else if (timeout_hit)
            tmo_d = 1'b1;
        else if (state_q == S_RESP && rsp_ready_i)
            tmo_d = 1'b0;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign rsp_timeout_o = tmo_q;
`else
    assign timeout_hit   = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid_i) state_d = misaligned ? S_RESP : S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (PREADY || timeout_hit) state_d = S_RESP;
            S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Write data is captured as zero for reads so PWDATA stays quiet on read transfers.
    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_write_i ? req_wdata_i : 32'h0;
                    rdata_d = 32'h0;
                    err_d   = misaligned;
                end
            end
            S_ACCESS: begin
                if (PREADY) begin
                    err_d   = PSLVERR;
                    rdata_d = (!write_q && !PSLVERR) ? PRDATA : 32'h0;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        apb_busy    = (state_q == S_SETUP) || (state_q == S_ACCESS);
        req_ready_o = HRESETn && (state_q == S_IDLE);
        PSEL        = apb_busy;
        PENABLE     = (state_q == S_ACCESS);
        PWRITE      = apb_busy ? write_q : 1'b0;
        PADDR       = apb_busy ? addr_q : '0;
        PWDATA      = apb_busy ? wdata_q : 32'h0;
        rsp_valid_o = (state_q == S_RESP);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
    end
endmodule

// File: tb/tb_apb_timer_cfg_master.sv
// Bench for apb_timer_cfg_master: vector table, randomized commands against a response model, reset and timeout sequences.
module tb_apb_timer_cfg_master;
    localparam int AW = 12;
    localparam int TO = 16;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          req_valid_i = 1'b0, req_ready_o;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [31:0]   req_wdata_i = '0;
    logic          rsp_valid_o, rsp_ready_i = 1'b0;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o, rsp_timeout_o;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PREADY = 1'b0;
    logic [31:0]   PRDATA = '0;
    logic          PSLVERR = 1'b0;

    apb_timer_cfg_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            waits;
        logic [31:0]   prdata;
        logic          slverr;
        int            hold;
        logic          exp_err;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response model: a misaligned address never reaches APB; otherwise the slave's error wins over data.
    function automatic void model_rsp(input logic wr, input logic [AW-1:0] a, input logic slv,
                                      input logic [31:0] prd, output logic e, output logic [31:0] rd);
        if ((int'(a) % 4) != 0) begin
            e  = 1'b1;
            rd = 32'h0;
        end else begin
            e  = slv;
            rd = (wr || slv) ? 32'h0 : prd;
        end
    endfunction

    task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] a,
                           input logic [31:0] wd, input int waits, input logic [31:0] prd,
                           input logic slv, input int hold, input logic exp_err,
                           input logic [31:0] exp_rd);
        logic [31:0] exp_pw;
        exp_pw = wr ? wd : 32'h0;
        chk({tag, ":idle_ready"}, {31'h0, req_ready_o}, 32'h1);
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = a; req_wdata_i = wd;
        @(negedge HCLK);
        req_valid_i = 1'b0; req_write_i = 1'($urandom); req_addr_i = AW'($urandom); req_wdata_i = $urandom;
        chk({tag, ":ready_busy"}, {31'h0, req_ready_o}, 32'h0);
        if ((int'(a) % 4) == 0) begin
            chk({tag, ":setup_psel"}, {31'h0, PSEL}, 32'h1);
            chk({tag, ":setup_penable"}, {31'h0, PENABLE}, 32'h0);
            chk({tag, ":setup_paddr"}, 32'(PADDR), 32'(a));
            chk({tag, ":setup_pwrite"}, {31'h0, PWRITE}, {31'h0, wr});
            chk({tag, ":setup_pwdata"}, PWDATA, exp_pw);
            @(negedge HCLK);
            for (int w = 0; w <= waits; w++) begin
                chk({tag, ":acc_psel"}, {31'h0, PSEL}, 32'h1);
                chk({tag, ":acc_penable"}, {31'h0, PENABLE}, 32'h1);
                chk({tag, ":acc_paddr"}, 32'(PADDR), 32'(a));
                chk({tag, ":acc_pwrite"}, {31'h0, PWRITE}, {31'h0, wr});
                chk({tag, ":acc_pwdata"}, PWDATA, exp_pw);
                chk({tag, ":acc_rsp_valid"}, {31'h0, rsp_valid_o}, 32'h0);
                PREADY  = (w == waits);
                PRDATA  = PREADY ? prd : $urandom;
                PSLVERR = PREADY ? slv : 1'($urandom);
                @(negedge HCLK);
            end
            PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
            chk({tag, ":resp_penable"}, {31'h0, PENABLE}, 32'h0);
        end
        for (int h = 0; h <= hold; h++) begin
            chk({tag, ":rsp_valid"}, {31'h0, rsp_valid_o}, 32'h1);
            chk({tag, ":rsp_err"}, {31'h0, rsp_err_o}, {31'h0, exp_err});
            chk({tag, ":rsp_rdata"}, rsp_rdata_o, exp_rd);
            chk({tag, ":rsp_timeout"}, {31'h0, rsp_timeout_o}, 32'h0);
            chk({tag, ":rsp_ready_lo"}, {31'h0, req_ready_o}, 32'h0);
            chk({tag, ":rsp_psel"}, {31'h0, PSEL}, 32'h0);
            if (h < hold) begin
                req_valid_i = 1'b1; rsp_ready_i = 1'b0;
                PRDATA = $urandom; PSLVERR = 1'($urandom);
            end else begin
                req_valid_i = 1'b0; rsp_ready_i = 1'b1;
            end
            @(negedge HCLK);
        end
        rsp_ready_i = 1'b0;
        chk({tag, ":after_valid"}, {31'h0, rsp_valid_o}, 32'h0);
        chk({tag, ":after_err"}, {31'h0, rsp_err_o}, 32'h0);
        chk({tag, ":after_rdata"}, rsp_rdata_o, 32'h0);
        chk({tag, ":after_ready"}, {31'h0, req_ready_o}, 32'h1);
    endtask

    initial begin
        logic          r_wr, r_slv, e_err;
        logic [AW-1:0] r_addr;
        logic [31:0]   r_wd, r_prd, e_rd;
        int            n;

        tbl[0] = '{1'b1, 12'h004, 32'h0000_00FF, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 12'h008, 32'hFFFF_FFFF, 3, 32'h1234_5678, 1'b0, 0, 1'b0, 32'h1234_5678};
        tbl[2] = '{1'b0, 12'h00C, 32'h0,         0, 32'hCAFE_F00D, 1'b1, 0, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 12'h002, 32'h0,         0, 32'h1111_1111, 1'b0, 0, 1'b1, 32'h0};
        tbl[4] = '{1'b1, 12'h010, 32'hA5A5_5A5A, 1, 32'h2222_2222, 1'b1, 1, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 12'h7FC, 32'h0,         0, 32'h8765_4321, 1'b0, 5, 1'b0, 32'h8765_4321};
        tbl[6] = '{1'b1, 12'h001, 32'h5555_AAAA, 0, 32'h0,         1'b0, 2, 1'b1, 32'h0};
        tbl[7] = '{1'b0, 12'hFFC, 32'h0,         2, 32'hFFFF_0001, 1'b0, 0, 1'b0, 32'hFFFF_0001};

        repeat (3) @(negedge HCLK);
        chk("rst_ready_held", {31'h0, req_ready_o}, 32'h0);
        chk("rst_psel", {31'h0, PSEL}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_paddr", 32'(PADDR), 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err_o}, 32'h0);
        chk("rst_rsp_timeout", {31'h0, rsp_timeout_o}, 32'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_release_ready", {31'h0, req_ready_o}, 32'h1);

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits,
                    tbl[i].prdata, tbl[i].slverr, tbl[i].hold, tbl[i].exp_err, tbl[i].exp_rdata);

        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom);
            r_addr = AW'($urandom);
            if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
            r_wd   = $urandom;
            r_prd  = $urandom;
            r_slv  = ($urandom_range(0, 4) == 0);
            model_rsp(r_wr, r_addr, r_slv, r_prd, e_err, e_rd);
            run_txn($sformatf("rnd%0d", i), r_wr, r_addr, r_wd, $urandom_range(0, 4),
                    r_prd, r_slv, $urandom_range(0, 3), e_err, e_rd);
        end

        // PREADY never rises: either the abort fires or the transfer is held indefinitely.
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 12'h020;
        @(negedge HCLK);
        req_valid_i = 1'b0; PREADY = 1'b0;
        @(negedge HCLK);
        n = 0;
        while (PENABLE === 1'b1 && n < 200) begin
            n++;
            @(negedge HCLK);
        end
`ifdef APB_TIMER_CFG_MASTER_TIMEOUT_EN
        chk("tmo_access_cycles", n, TO);
        chk("tmo_psel", {31'h0, PSEL}, 32'h0);
        chk("tmo_rsp_valid", {31'h0, rsp_valid_o}, 32'h1);
        chk("tmo_rsp_err", {31'h0, rsp_err_o}, 32'h1);
        chk("tmo_rsp_timeout", {31'h0, rsp_timeout_o}, 32'h1);
        chk("tmo_rsp_rdata", rsp_rdata_o, 32'h0);
        rsp_ready_i = 1'b1;
        @(negedge HCLK);
        rsp_ready_i = 1'b0;
        chk("tmo_after_timeout", {31'h0, rsp_timeout_o}, 32'h0);
        chk("tmo_after_ready", {31'h0, req_ready_o}, 32'h1);
`else
        chk("hold_access_cycles", n, 200);
        chk("hold_psel", {31'h0, PSEL}, 32'h1);
        chk("hold_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
        chk("hold_timeout_flag", {31'h0, rsp_timeout_o}, 32'h0);
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("hold_recover_ready", {31'h0, req_ready_o}, 32'h1);
`endif

        // Reset in the middle of ACCESS discards the transfer.
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 12'h030;
        @(negedge HCLK);
        req_valid_i = 1'b0;
        @(negedge HCLK);
        chk("arst_in_access", {31'h0, PENABLE}, 32'h1);
        HRESETn = 1'b0;
        PREADY = 1'b1; PRDATA = 32'h0BAD_0BAD;
        @(negedge HCLK);
        PREADY = 1'b0;
        chk("arst_psel", {31'h0, PSEL}, 32'h0);
        chk("arst_penable", {31'h0, PENABLE}, 32'h0);
        chk("arst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("arst_ready_held", {31'h0, req_ready_o}, 32'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("arst_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
        chk("arst_rdata", rsp_rdata_o, 32'h0);
        run_txn("post_rst", 1'b1, 12'h040, 32'h1357_9BDF, 1, 32'h0, 1'b0, 0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
